// File: rtl/bitstring_tx.sv
// Serial bit-string transmitter: loads a word plus length, shifts it out MSB first,
// optionally followed by a fixed terminating bit. Every output is a flop.
module bitstring_tx #(
    parameter int unsigned W          = 8,
    parameter int unsigned LW         = 4,
    parameter bit          APPEND_END = 1'b1,
    parameter logic        END_VAL    = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  data,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          out,
    output logic          out_valid,
    output logic          out_last,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

    localparam logic [LW-1:0] WL = LW'(W);

    state_t        state, state_n;
    logic [LW-1:0] cnt, cnt_n;
    logic [W-1:0]  sreg, sreg_n;
    logic [LW-1:0] eff_len;
    logic          busy_n, out_n, valid_n, last_n, done_n;
    logic          zpend, zpend_n, zhold, zhold_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            busy      <= 1'b0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            zpend     <= 1'b0;
            zhold     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sreg      <= sreg_n;
            busy      <= busy_n;
            out       <= out_n;
            out_valid <= valid_n;
            out_last  <= last_n;
            done      <= done_n;
            zpend     <= zpend_n;
            zhold     <= zhold_n;
        end
    end

    always_comb begin
        eff_len = (len > WL) ? WL : len;
        state_n = state;
        cnt_n   = cnt;
        sreg_n  = sreg;
        busy_n  = 1'b0;
        out_n   = 1'b0;
        valid_n = 1'b0;
        last_n  = 1'b0;
        zpend_n = 1'b0;
        // An empty payload without a tail still occupies one virtual bit slot,
        // so its done pulse lands where a one-bit string's would.
        zhold_n = zpend;
        done_n  = out_last | zhold;

        case (state)
            IDLE: begin
                if (start) begin
                    // Left-align the payload so bit len-1 sits at the MSB.
                    sreg_n = data << (WL - eff_len);
                    cnt_n  = eff_len;
                    if (eff_len != '0) begin
                        state_n = SHIFT;
                    end else if (APPEND_END) begin
                        state_n = TAIL;
                    end else begin
                        zpend_n = 1'b1;
                    end
                end
            end
            SHIFT: begin
                busy_n  = 1'b1;
                valid_n = 1'b1;
                out_n   = sreg[W-1];
                sreg_n  = sreg << 1;
                cnt_n   = cnt - 1'b1;
                if (cnt == LW'(1)) begin
                    if (APPEND_END) begin
                        state_n = TAIL;
                    end else begin
                        last_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            TAIL: begin
                busy_n  = 1'b1;
                valid_n = 1'b1;
                out_n   = END_VAL;
                last_n  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bitstring_tx.sv
// Scoreboard bench for bitstring_tx: two instances (with and without the
// terminating bit) share stimulus; a monitor compares every cycle against queued expectations.
module tb_bitstring_tx;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data  = '0;
    logic [3:0] len   = '0;
    logic [1:0] busy, out, ov, ol, done;

    bitstring_tx #(.W(8), .LW(4), .APPEND_END(1'b1), .END_VAL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .data(data), .len(len),
        .busy(busy[0]), .out(out[0]), .out_valid(ov[0]), .out_last(ol[0]), .done(done[0])
    );

    bitstring_tx #(.W(8), .LW(4), .APPEND_END(1'b0), .END_VAL(1'b1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .data(data), .len(len),
        .busy(busy[1]), .out(out[1]), .out_valid(ov[1]), .out_last(ol[1]), .done(done[1])
    );

    always #5 clk = ~clk;

    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int unsigned e;
        logic        b;
        logic        last;
    } bit_t;

    bit_t        bq[2][$];
    int unsigned dq[2][$];
    int unsigned ready_e[2];
    int unsigned total  = 0;
    int unsigned passed = 0;
    logic [4:0]  mexp;

    task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got={busy,valid,out,last,done}=%b expected=%b", name, got, exp);
    endtask

    // Reference model: start is sampled at edge e; a free transmitter emits
    // eff_len payload bits (MSB first) plus the optional end bit on edges e+1...
    task automatic model_edge(input int unsigned e);
        for (int i = 0; i < 2; i++) begin
            if (e >= ready_e[i]) begin
                int   eff;
                int   n;
                int   pos;
                bit_t x;
                eff = (len > 4'd8) ? 8 : int'(len);
                n   = eff + ((i == 0) ? 1 : 0);
                pos = 0;
                for (int k = eff - 1; k >= 0; k--) begin
                    x.e = e + 1 + pos; x.b = data[k]; x.last = (pos == n - 1);
                    bq[i].push_back(x);
                    pos++;
                end
                if (i == 0) begin
                    x.e = e + 1 + pos; x.b = 1'b0; x.last = 1'b1;
                    bq[i].push_back(x);
                end
                if (n > 0) begin
                    dq[i].push_back(e + n + 1);
                    ready_e[i] = e + n + 1;
                end else begin
                    dq[i].push_back(e + 2);
                    ready_e[i] = e + 1;
                end
            end
        end
    endtask

    task automatic cyc(input logic s, input logic [7:0] d, input logic [3:0] l);
        start = s;
        data  = d;
        len   = l;
        if (s) model_edge(edge_n + 1);
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) cyc(1'b0, 8'($urandom), 4'($urandom));
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mexp = '0;
            if (bq[i].size() > 0 && bq[i][0].e == edge_n) begin
                mexp[4] = 1'b1;
                mexp[3] = 1'b1;
                mexp[2] = bq[i][0].b;
                mexp[1] = bq[i][0].last;
                void'(bq[i].pop_front());
            end
            if (dq[i].size() > 0 && dq[i][0] == edge_n) begin
                mexp[0] = 1'b1;
                void'(dq[i].pop_front());
            end
            chk($sformatf("dut%0d_edge%0d", i, edge_n),
                {busy[i], ov[i], out[i], ol[i], done[i]}, mexp);
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ready_e[0] = edge_n + 1;
        ready_e[1] = edge_n + 1;

        cyc(1'b1, 8'b1011_0010, 4'd8);
        idle(11);
        cyc(1'b1, 8'h05, 4'd3);
        idle(6);
        cyc(1'b1, 8'hFF, 4'd0);
        idle(4);

        cyc(1'b1, 8'hA7, 4'd8);
        idle(2);
        cyc(1'b1, 8'h3C, 4'd5);
        idle(2);
        repeat (14) cyc(1'b1, 8'h5A, 4'd6);
        idle(10);

        cyc(1'b1, 8'hC3, 4'd12);
        idle(11);

        cyc(1'b1, 8'h6D, 4'd8);
        idle(3);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("async_reset_dut%0d", i), {busy[i], ov[i], out[i], ol[i], done[i]}, 5'b0);
            bq[i].delete();
            dq[i].delete();
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ready_e[0] = edge_n + 1;
        ready_e[1] = edge_n + 1;
        cyc(1'b1, 8'h96, 4'd7);
        idle(10);

        repeat (200) begin
            if ($urandom_range(0, 3) == 0) cyc(1'b1, 8'($urandom), 4'($urandom));
            else                            cyc(1'b0, 8'($urandom), 4'($urandom));
        end
        idle(14);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
